nbody_sched: RTL
================

NBODY_SCHED -- requirements
Module: nbody_sched

Interface
REQ-001 Parameter BODIES, default 512: maximum body count; power of two assumed.
REQ-002 Parameter DATA_WIDTH, default 64: bus and body-data word width.
REQ-003 Parameter ADDR_WIDTH, default 16: bus address width.
REQ-004 Parameter BW, default $clog2(BODIES): body index width.
REQ-005 Parameter ACC_LAT, default 58: fixed cycles from pair issue to its result in the external accumulate pipeline.
REQ-006 Parameter UPD_LAT, default 31: fixed cycles from update issue to its position result in the external update pipeline.
REQ-007 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-008 chipselect, read, write  in  1 each  bus qualifiers; a bus access occurs only when chipselect=1.
REQ-009 addr  in  ADDR_WIDTH  bits [ADDR_WIDTH-1:BW] = opcode, bits [BW-1:0] = body index.
REQ-010 write_data  in  DATA_WIDTH  bus write data; read_data  out  DATA_WIDTH  registered read data.
REQ-011 sw_wr_en  out  1; sw_wr_sel  out  3; sw_wr_idx  out  BW; sw_wr_data  out  DATA_WIDTH  body-memory write forward (sel 0=x, 1=y, 2=m, 3=vx, 4=vy).
REQ-012 pair_valid  out  1; pair_i, pair_j  out  BW; pair_first, pair_last  out  1  pair issue to the accumulate pipeline.
REQ-013 vel_wr_en  out  1; vel_wr_idx  out  BW  velocity write-back strobe for body i.
REQ-014 upd_valid  out  1; upd_idx  out  BW; pos_wr_en  out  1; pos_wr_idx  out  BW  position update issue and write-back.
REQ-015 busy, done  out  1  status.

Function
REQ-016 Opcodes: 0x00 CTRL (wr bit0=go, bit1=abort); 0x02 N_BODIES (wr); 0x08 STEPS (wr); 0x03..0x07 body write x,y,m,vx,vy; 0x40 STATUS (rd: bit0 done, bit1 busy, bit2 err); 0x41 STEP_COUNT (rd).
REQ-017 N_BODIES register width BW+1; written values above BODIES clamp to BODIES.
REQ-018 STEPS register 32 bits; STEPS=0 executes as 1.
REQ-019 Reads: read_data valid one cycle after the read access; unmapped opcodes return 0.
REQ-020 Body writes in IDLE: sw_wr_en=1 for exactly one cycle, sel=opcode-3, idx=addr[BW-1:0], data=write_data; body writes in any other state are dropped.
REQ-021 States: IDLE, ACCEL, DRAIN_A, UPDATE, DRAIN_U, DONE.
REQ-022 IDLE->ACCEL on a go write with N>=2; clears step_count and err. A go write with N<2 sets err and stays in IDLE.
REQ-023 ACCEL: one pair per cycle, i outer 0..N-1, j inner 0..N-1, skipping j==i; N*(N-1) pairs total.
REQ-024 pair_first marks the first issued j for each i; pair_last marks the last issued j for each i (both are set when N=2).
REQ-025 vel_wr_en pulses exactly ACC_LAT cycles after each pair_last, with vel_wr_idx = that pair_i (delay line of valid bit + index).
REQ-026 After the last pair, ACCEL->DRAIN_A; DRAIN_A->UPDATE on the cycle after the final vel_wr_en.
REQ-027 UPDATE: upd_valid for idx 0..N-1, one per cycle; pos_wr_en/pos_wr_idx exactly UPD_LAT cycles after each issue.
REQ-028 DRAIN_U ends on the cycle after the final pos_wr_en and increments step_count; it goes to DONE if step_count+1 >= max(STEPS,1), otherwise to ACCEL.
REQ-029 busy=1 in ACCEL, DRAIN_A, UPDATE and DRAIN_U; done=1 only in DONE.
REQ-030 DONE->IDLE on the cycle after a STATUS read (the read returns done=1); go writes in DONE are ignored.
REQ-031 Abort write in any non-IDLE state: next state IDLE; both delay lines flush, so no vel_wr_en or pos_wr_en occurs afterwards; step_count is retained.
REQ-032 A CTRL write with both go and abort set is treated as abort only.
REQ-033 A go write while busy is ignored; N_BODIES and STEPS writes while busy are dropped.

Reset
REQ-034 On rst: state IDLE; N_BODIES=0, STEPS=0, step_count=0, err=0; all strobes, busy, done and read_data are 0; delay lines are cleared.
REQ-035 rst asserted mid-operation takes effect immediately; no strobe may appear after rst rises.

Verification
REQ-036 N=3, STEPS=1, ACC_LAT=4, UPD_LAT=2, go -> 6 pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1); vel_wr_idx 0,1,2 each 4 cycles after its pair_last; pos_wr_idx 0,1,2; done=1; STEP_COUNT=1.
REQ-037 N=2, STEPS=3 -> three full step sequences, each with 2 pairs (pair_first=pair_last=1), then done; STEP_COUNT read returns 3.
REQ-038 go with N=1 -> state stays IDLE, STATUS=0x4; no pair_valid.
REQ-039 Abort during DRAIN_A, 2 cycles before the final vel_wr_en -> no further vel_wr_en or pos_wr_en; busy=0 on the next cycle.
REQ-040 Body write opcode 0x05, idx 7 in IDLE -> sw_wr_sel=2, sw_wr_idx=7 for one cycle; the same write while busy -> sw_wr_en stays 0.
REQ-041 N_BODIES write of 1000 with BODIES=512 -> N=512; in DONE, a STATUS read returns 0x1 and the block is in IDLE the next cycle.

Source files
------------

// File: rtl/nbody_sched_if.sv
// rtl/nbody_sched_if.sv - register bus bundle for the n-body scheduler
// Purpose: groups the host register bus so the scheduler and its host share one port.
// Signals: chipselect/read/write qualifiers, addr (opcode | body index),
//          write_data from host, read_data (registered) back to host.
// Modports: master = host side, slave = scheduler side.
interface nbody_sched_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output chipselect, read, write, addr, write_data,
    input  read_data
  );

  modport slave (
    input  chipselect, read, write, addr, write_data,
    output read_data
  );
endinterface

// File: rtl/nbody_sched.sv
// rtl/nbody_sched.sv - n-body timestep scheduler: pair/update issue with latency-matched write-back
// Purpose: sequences one simulation step as all ordered (i,j) pairs to an external
//          accumulate pipeline, then one position update per body, repeated STEPS times.
// Ports: clk, rst (async, active-high); bus (register slave);
//        sw_wr_*  body-memory write forward of host body writes;
//        pair_*   pair issue; vel_wr_* velocity write-back strobe (ACC_LAT after row end);
//        upd_*    update issue; pos_wr_* position write-back strobe (UPD_LAT after issue);
//        busy, done status.
module nbody_sched #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int BW         = $clog2(BODIES),
  parameter int ACC_LAT    = 58,
  parameter int UPD_LAT    = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  nbody_sched_if.slave          bus,
  output logic                  sw_wr_en,
  output logic [2:0]            sw_wr_sel,
  output logic [BW-1:0]         sw_wr_idx,
  output logic [DATA_WIDTH-1:0] sw_wr_data,
  output logic                  pair_valid,
  output logic [BW-1:0]         pair_i,
  output logic [BW-1:0]         pair_j,
  output logic                  pair_first,
  output logic                  pair_last,
  output logic                  vel_wr_en,
  output logic [BW-1:0]         vel_wr_idx,
  output logic                  upd_valid,
  output logic [BW-1:0]         upd_idx,
  output logic                  pos_wr_en,
  output logic [BW-1:0]         pos_wr_idx,
  output logic                  busy,
  output logic                  done
);
  localparam int OW = ADDR_WIDTH - BW;
  localparam logic [OW-1:0] OP_CTRL   = OW'('h00);
  localparam logic [OW-1:0] OP_NB     = OW'('h02);
  localparam logic [OW-1:0] OP_X      = OW'('h03);
  localparam logic [OW-1:0] OP_VY     = OW'('h07);
  localparam logic [OW-1:0] OP_STEPS  = OW'('h08);
  localparam logic [OW-1:0] OP_STATUS = OW'('h40);
  localparam logic [OW-1:0] OP_STEPC  = OW'('h41);

  typedef enum logic [2:0] {IDLE, ACCEL, DRAIN_A, UPDATE, DRAIN_U, DONE} state_t;
  state_t state, state_next;

  logic [OW-1:0] opcode;
  logic          wr_acc, rd_acc, ctrl_wr, go_req, abort_req, status_rd, flush;
  logic [BW:0]   n_bodies;
  logic [31:0]   steps, step_count;
  logic          err;
  logic [BW-1:0] ci, cj, cu;
  logic [BW+1:0] j_inc, j_nx;
  logic          row_end, last_row, upd_last, vel_last, pos_last, step_final;

  assign opcode    = bus.addr[ADDR_WIDTH-1:BW];
  assign wr_acc    = bus.chipselect & bus.write;
  assign rd_acc    = bus.chipselect & bus.read;
  assign ctrl_wr   = wr_acc && (opcode == OP_CTRL);
  // abort dominates go when both bits are set
  assign abort_req = ctrl_wr & bus.write_data[1];
  assign go_req    = ctrl_wr & bus.write_data[0] & ~bus.write_data[1];
  assign status_rd = rd_acc && (opcode == OP_STATUS);
  assign flush     = abort_req && (state != IDLE);

  // next inner index, stepping over the diagonal; BW+2 bits so j+2 cannot wrap
  always_comb begin
    j_inc = {2'b00, cj} + (BW+2)'(1);
    j_nx  = (j_inc == {2'b00, ci}) ? {2'b00, cj} + (BW+2)'(2) : j_inc;
  end

  assign row_end    = j_nx >= {1'b0, n_bodies};
  assign last_row   = ({1'b0, ci} + (BW+1)'(1)) == n_bodies;
  assign upd_last   = ({1'b0, cu} + (BW+1)'(1)) == n_bodies;
  // bodies retire in ascending order, so the final write-back carries index N-1
  assign vel_last   = vel_wr_en && (({1'b0, vel_wr_idx} + (BW+1)'(1)) == n_bodies);
  assign pos_last   = pos_wr_en && (({1'b0, pos_wr_idx} + (BW+1)'(1)) == n_bodies);
  assign step_final = ({1'b0, step_count} + 33'd1) >= {1'b0, (steps == 32'd0) ? 32'd1 : steps};

  assign pair_i  = ci;
  assign pair_j  = cj;
  assign upd_idx = cu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pair_valid = 1'b0;
    pair_first = 1'b0;
    pair_last  = 1'b0;
    upd_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (go_req && n_bodies >= (BW+1)'(2)) state_next = ACCEL;
      ACCEL: begin
        busy       = 1'b1;
        pair_valid = 1'b1;
        pair_first = (cj == ((ci == '0) ? BW'(1) : BW'(0)));
        pair_last  = row_end;
        if (row_end && last_row) state_next = DRAIN_A;
      end
      DRAIN_A: begin
        busy = 1'b1;
        if (vel_last) state_next = UPDATE;
      end
      UPDATE: begin
        busy      = 1'b1;
        upd_valid = 1'b1;
        if (upd_last) state_next = DRAIN_U;
      end
      DRAIN_U: begin
        busy = 1'b1;
        if (pos_last) state_next = step_final ? DONE : ACCEL;
      end
      DONE: begin
        done = 1'b1;
        if (status_rd) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // loop counters rest at their start values outside their phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ci <= '0;
      cj <= BW'(1);
      cu <= '0;
    end else begin
      if (state != ACCEL) begin
        ci <= '0;
        cj <= BW'(1);
      end else if (row_end) begin
        ci <= ci + BW'(1);
        cj <= '0;
      end else begin
        cj <= j_nx[BW-1:0];
      end
      cu <= (state == UPDATE) ? cu + BW'(1) : '0;
    end
  end

  // write-back delay lines: valid bit plus body index, flushed on abort
  logic [ACC_LAT-1:0] acc_v;
  logic [BW-1:0]      acc_idx [ACC_LAT];
  logic [UPD_LAT-1:0] upd_v;
  logic [BW-1:0]      upd_idx_d [UPD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_v <= '0;
      upd_v <= '0;
      for (int k = 0; k < ACC_LAT; k++) acc_idx[k] <= '0;
      for (int k = 0; k < UPD_LAT; k++) upd_idx_d[k] <= '0;
    end else begin
      acc_v[0]     <= pair_valid & pair_last & ~flush;
      acc_idx[0]   <= ci;
      upd_v[0]     <= upd_valid & ~flush;
      upd_idx_d[0] <= cu;
      for (int k = 1; k < ACC_LAT; k++) begin
        acc_v[k]   <= acc_v[k-1] & ~flush;
        acc_idx[k] <= acc_idx[k-1];
      end
      for (int k = 1; k < UPD_LAT; k++) begin
        upd_v[k]     <= upd_v[k-1] & ~flush;
        upd_idx_d[k] <= upd_idx_d[k-1];
      end
    end
  end

  assign vel_wr_en  = acc_v[ACC_LAT-1];
  assign vel_wr_idx = acc_idx[ACC_LAT-1];
  assign pos_wr_en  = upd_v[UPD_LAT-1];
  assign pos_wr_idx = upd_idx_d[UPD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_wr_en      <= 1'b0;
      sw_wr_sel     <= '0;
      sw_wr_idx     <= '0;
      sw_wr_data    <= '0;
      n_bodies      <= '0;
      steps         <= '0;
      step_count    <= '0;
      err           <= 1'b0;
      bus.read_data <= '0;
    end else begin
      sw_wr_en <= 1'b0;
      if (wr_acc && state == IDLE && opcode >= OP_X && opcode <= OP_VY) begin
        sw_wr_en   <= 1'b1;
        sw_wr_sel  <= 3'(opcode - OP_X);
        sw_wr_idx  <= bus.addr[BW-1:0];
        sw_wr_data <= bus.write_data;
      end
      if (wr_acc && !busy && opcode == OP_NB)
        n_bodies <= (bus.write_data > DATA_WIDTH'(BODIES)) ? (BW+1)'(BODIES)
                                                           : bus.write_data[BW:0];
      if (wr_acc && !busy && opcode == OP_STEPS)
        steps <= bus.write_data[31:0];
      if (state == IDLE && go_req) begin
        if (n_bodies >= (BW+1)'(2)) begin
          step_count <= '0;
          err        <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == DRAIN_U && pos_last && !flush)
        step_count <= step_count + 32'd1;
      if (rd_acc) begin
        case (opcode)
          OP_STATUS: bus.read_data <= {{(DATA_WIDTH-3){1'b0}}, err, busy, done};
          OP_STEPC:  bus.read_data <= DATA_WIDTH'(step_count);
          default:   bus.read_data <= '0;
        endcase
      end
    end
  end
endmodule
